// File: rtl/mem_pkg.sv
// Shared helpers for the multi-port register-file memory: flat-bus slicing
// and write-port priority resolution used by both the write and bypass paths.
package mem_pkg;

    localparam int MAX_BUS   = 1024;
    localparam int MAX_WORD  = 64;
    localparam int MAX_PORTS = 32;
    localparam int DEPTH     = 16;

    typedef struct packed {
        logic       hit;
        logic       collide;
        logic [4:0] idx;
    } wr_sel_t;

    function automatic logic [MAX_WORD-1:0] bus_slice(
        input logic [MAX_BUS-1:0] bus,
        input int                 idx,
        input int                 width
    );
        logic [MAX_BUS-1:0]  shifted;
        logic [MAX_WORD-1:0] mask;
        shifted = bus >> (idx * width);
        mask    = {MAX_WORD{1'b1}};
        mask    = ~(mask << width);
        return shifted[MAX_WORD-1:0] & mask;
    endfunction

    // Ascending scan so the highest-index enabled port matching addr wins.
    function automatic wr_sel_t resolve_write(
        input logic [MAX_PORTS-1:0] we,
        input logic [MAX_BUS-1:0]   waddr,
        input logic [MAX_WORD-1:0]  addr,
        input int                   num_wr,
        input int                   aw
    );
        wr_sel_t r;
        r = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (i < num_wr && we[i] && bus_slice(waddr, i, aw) == addr) begin
                if (r.hit) r.collide = 1'b1;
                r.hit = 1'b1;
                r.idx = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_wr_resolve.sv
// Combinational lookup of the winning write for one query address, plus a
// flag when more than one enabled write port targets that address.
module mem_wr_resolve
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WR     = 2
) (
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]        qaddr,
    output logic                         hit,
    output logic [DATA_WIDTH-1:0]        data,
    output logic                         collide
);

    wr_sel_t             sel;
    logic [MAX_WORD-1:0] word;

    always_comb begin
        sel     = resolve_write(MAX_PORTS'(we), MAX_BUS'(waddr), MAX_WORD'(qaddr),
                                NUM_WR, ADDR_WIDTH);
        word    = bus_slice(MAX_BUS'(wdata), int'(sel.idx), DATA_WIDTH);
        hit     = sel.hit;
        collide = sel.collide;
        data    = word[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/mem_nw_mr.sv
// Parametrised register-file memory with NUM_WR write ports and NUM_RD
// registered read ports, write-collision priority and optional write-first reads.
module mem_nw_mr
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_RD-1:0]            re,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rvalid,
    output logic                         wcollide
);

    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [NUM_WR-1:0]     wr_hit;
    logic [NUM_WR-1:0]     wr_col;
    logic [DATA_WIDTH-1:0] wr_data [NUM_WR];

    logic [NUM_RD-1:0]     rd_hit;
    logic [DATA_WIDTH-1:0] rd_byp  [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_next [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_q    [NUM_RD];

    // Every write port stores the winning data for its own address, so
    // colliding ports all write the same value and NBA ordering is irrelevant.
    for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
        mem_wr_resolve #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .NUM_WR    (NUM_WR)
        ) u_resolve (
            .we     (we),
            .waddr  (waddr),
            .wdata  (wdata),
            .qaddr  (waddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .hit    (wr_hit[i]),
            .data   (wr_data[i]),
            .collide(wr_col[i])
        );
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        mem_wr_resolve #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .NUM_WR    (NUM_WR)
        ) u_resolve (
            .we     (we),
            .waddr  (waddr),
            .wdata  (wdata),
            .qaddr  (raddr[j*ADDR_WIDTH +: ADDR_WIDTH]),
            .hit    (rd_hit[j]),
            .data   (rd_byp[j]),
            .collide()
        );
        assign rdata[j*DATA_WIDTH +: DATA_WIDTH] = rd_q[j];
    end

    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            rd_next[j] = mem[raddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
            if (BYPASS != 0 && rd_hit[j]) rd_next[j] = rd_byp[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MEM_DEPTH; k++) mem[k] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (we[i] && wr_hit[i]) mem[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM_RD; j++) rd_q[j] <= '0;
            rvalid   <= '0;
            wcollide <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_RD; j++) begin
                if (re[j]) rd_q[j] <= rd_next[j];
            end
            rvalid   <= re;
            wcollide <= |(we & wr_col);
        end
    end

endmodule

// File: tb/tb_mem_nw_mr.sv
// Directed bench for mem_nw_mr: one instance with old-data reads and one
// with write-first reads, driven by the same stimulus.
module tb_mem_nw_mr;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  re;
    logic [7:0]  raddr;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  rvalid0, rvalid1;
    logic        wcollide0, wcollide1;

    int checks = 0;
    int errors = 0;

    mem_nw_mr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_WR(2), .NUM_RD(2), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .wcollide(wcollide0)
    );

    mem_nw_mr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_WR(2), .NUM_RD(2), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .wcollide(wcollide1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus, then land 1 time unit after the rising edge.
    task automatic applyStimulus(input logic [1:0] w_en, input logic [3:0] wa0, input logic [3:0] wa1,
                                 input logic [7:0] wd0, input logic [7:0] wd1,
                                 input logic [1:0] r_en, input logic [3:0] ra0, input logic [3:0] ra1);
        we    = w_en;
        waddr = {wa1, wa0};
        wdata = {wd1, wd0};
        re    = r_en;
        raddr = {ra1, ra0};
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset_rdata", 32'(rdata0), 32'h0);
        checkOutput("reset_rvalid", 32'(rvalid0), 32'h0);
        checkOutput("reset_wcollide", 32'(wcollide0), 32'h0);
        rst = 1'b0;

        // Build up non-zero state, then clear it with an asynchronous reset.
        applyStimulus(2'b01, 4'd3, 4'd0, 8'hAA, 8'h00, 2'b00, 4'd0, 4'd0);
        applyStimulus(2'b11, 4'd10, 4'd10, 8'h01, 8'h02, 2'b11, 4'd3, 4'd3);
        checkOutput("preload_rdata", 32'(rdata0), 32'hAAAA);
        checkOutput("preload_rvalid", 32'(rvalid0), 32'h3);
        checkOutput("preload_wcollide", 32'(wcollide0), 32'h1);
        we = '0; re = '0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rdata", 32'(rdata0), 32'h0);
        checkOutput("async_rvalid", 32'(rvalid0), 32'h0);
        checkOutput("async_wcollide", 32'(wcollide0), 32'h0);
        applyStimulus(2'b01, 4'd3, 4'd0, 8'h5A, 8'h00, 2'b11, 4'd3, 4'd3);
        checkOutput("rst_read_ignored", 32'(rvalid0), 32'h0);
        rst = 1'b0;
        applyStimulus(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01, 4'd3, 4'd0);
        checkOutput("post_reset_addr3", 32'(rdata0[7:0]), 32'h00);
        checkOutput("post_reset_rvalid", 32'(rvalid0), 32'h1);

        // Basic latency and hold.
        applyStimulus(2'b01, 4'd5, 4'd0, 8'h3C, 8'h00, 2'b00, 4'd0, 4'd0);
        checkOutput("write_only_rvalid", 32'(rvalid0), 32'h0);
        applyStimulus(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01, 4'd5, 4'd0);
        checkOutput("latency_rdata0", 32'(rdata0[7:0]), 32'h3C);
        checkOutput("latency_rvalid", 32'(rvalid0), 32'h1);
        applyStimulus(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 4'd5, 4'd0);
        checkOutput("hold_rdata0", 32'(rdata0[7:0]), 32'h3C);
        checkOutput("hold_rvalid", 32'(rvalid0), 32'h0);

        // Write collision: highest-index port wins.
        applyStimulus(2'b11, 4'd7, 4'd7, 8'h11, 8'h22, 2'b00, 4'd0, 4'd0);
        checkOutput("collide_flag", 32'(wcollide0), 32'h1);
        applyStimulus(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01, 4'd7, 4'd0);
        checkOutput("collide_flag_drop", 32'(wcollide0), 32'h0);
        checkOutput("collide_winner", 32'(rdata0[7:0]), 32'h22);
        checkOutput("collide_winner_byp", 32'(rdata1[7:0]), 32'h22);
        applyStimulus(2'b11, 4'd1, 4'd2, 8'hA1, 8'hB2, 2'b00, 4'd0, 4'd0);
        checkOutput("distinct_no_collide", 32'(wcollide0), 32'h0);
        applyStimulus(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b11, 4'd1, 4'd2);
        checkOutput("distinct_both_written", 32'(rdata0), 32'hB2A1);

        // Read-during-write on address 9.
        applyStimulus(2'b01, 4'd9, 4'd0, 8'h55, 8'h00, 2'b00, 4'd0, 4'd0);
        applyStimulus(2'b10, 4'd0, 4'd9, 8'h00, 8'h66, 2'b10, 4'd0, 4'd9);
        checkOutput("rdw_old_data", 32'(rdata0[15:8]), 32'h55);
        checkOutput("rdw_write_first", 32'(rdata1[15:8]), 32'h66);
        applyStimulus(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b10, 4'd0, 4'd9);
        checkOutput("rdw_next_read", 32'(rdata0[15:8]), 32'h66);
        checkOutput("rdw_next_read_byp", 32'(rdata1[15:8]), 32'h66);
        applyStimulus(2'b11, 4'd9, 4'd9, 8'h77, 8'h88, 2'b10, 4'd0, 4'd9);
        checkOutput("rdw_collide_old", 32'(rdata0[15:8]), 32'h66);
        checkOutput("rdw_collide_byp", 32'(rdata1[15:8]), 32'h88);
        checkOutput("rdw_collide_flag_byp", 32'(wcollide1), 32'h1);
        applyStimulus(2'b01, 4'd9, 4'd0, 8'h99, 8'h00, 2'b01, 4'd9, 4'd0);
        checkOutput("rdw_port0_old", 32'(rdata0[7:0]), 32'h88);
        checkOutput("rdw_port0_byp", 32'(rdata1[7:0]), 32'h99);

        // Dual independent reads with swapped addresses.
        applyStimulus(2'b11, 4'd4, 4'd15, 8'h9D, 8'hE1, 2'b00, 4'd0, 4'd0);
        applyStimulus(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b11, 4'd4, 4'd15);
        checkOutput("dual_read_a", 32'(rdata0), 32'hE19D);
        checkOutput("dual_rvalid", 32'(rvalid0), 32'h3);
        applyStimulus(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b11, 4'd15, 4'd4);
        checkOutput("dual_read_swap", 32'(rdata0), 32'h9DE1);
        applyStimulus(2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b11, 4'd4, 4'd4);
        checkOutput("dual_read_same", 32'(rdata0), 32'h9D9D);
        checkOutput("dual_rvalid_same", 32'(rvalid0), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
